puf_eval_seq: RTL

- Parametrised evaluation sequencer for a bank of N_ARC PUF cores.
- Successor to the fixed three-core controller:
  - core count, response-buffer depth and counter widths are parameters;
  - the core selection is latched for the whole run;
  - core-side handshakes are synchronised into the controller clock domain;
  - adds abort, saturating statistics and a captured-response count.
- Sits between the register/host interface and the per-architecture cores, one clock domain.

---
 rtl/puf_eval_seq_if.sv | 45 ++++
 rtl/puf_eval_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/puf_eval_seq_if.sv
// rtl/puf_eval_seq_if.sv - host/core signal bundle for puf_eval_seq
// i_tmo exists only when PUF_EVAL_SEQ_WDOG_EN is defined.
interface puf_eval_seq_if #(
  parameter int N_ARC  = 3,
  parameter int SEL_W  = 2,
  parameter int AUTH_W = 128,
  parameter int CNT_W  = 16
);
  logic              i_go;
  logic              i_abort;
  logic [SEL_W-1:0]  i_arc;
  logic [CNT_W-1:0]  i_evx;
  logic [CNT_W-1:0]  i_scc_begin;
  logic [CNT_W-1:0]  i_scc_end;
  logic [N_ARC-1:0]  i_q;
  logic [N_ARC-1:0]  i_valid;
  logic [N_ARC-1:0]  i_done;
`ifdef PUF_EVAL_SEQ_WDOG_EN
  logic [CNT_W-1:0]  i_tmo;
`endif
  logic [N_ARC-1:0]  o_go;
  logic [AUTH_W-1:0] o_auth;
  logic [CNT_W-1:0]  o_stat;
  logic [CNT_W-1:0]  o_nresp;
  logic              o_save;
  logic              o_busy;
  logic              o_err;
  logic              o_done;

  modport master (
    output i_go, i_abort, i_arc, i_evx, i_scc_begin, i_scc_end, i_q, i_valid, i_done,
`ifdef PUF_EVAL_SEQ_WDOG_EN
    output i_tmo,
`endif
    input  o_go, o_auth, o_stat, o_nresp, o_save, o_busy, o_err, o_done
  );

  modport slave (
    input  i_go, i_abort, i_arc, i_evx, i_scc_begin, i_scc_end, i_q, i_valid, i_done,
`ifdef PUF_EVAL_SEQ_WDOG_EN
    input  i_tmo,
`endif
    output o_go, o_auth, o_stat, o_nresp, o_save, o_busy, o_err, o_done
  );
endinterface

// File: rtl/puf_eval_seq.sv
// rtl/puf_eval_seq.sv - evaluation sequencer for a bank of N_ARC PUF cores
// Optional run watchdog enabled by defining PUF_EVAL_SEQ_WDOG_EN.
module puf_eval_seq #(
  parameter int N_ARC  = 3,
  parameter int SEL_W  = 2,
  parameter int AUTH_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  puf_eval_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_WAITLOW = 3'd3;
  localparam logic [2:0] S_FIN     = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;
  localparam logic [SEL_W:0] N_SEL = (SEL_W+1)'(N_ARC);

  logic [1:0]        go_sync_q;
  logic [N_ARC-1:0]  valid_s1_q, valid_s2_q, valid_prev_q;
  logic [N_ARC-1:0]  q_s1_q, q_s2_q, done_s1_q, done_s2_q;
  logic [2:0]        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  evx_q, evx_d, scc_q, scc_d;
  logic [CNT_W-1:0]  stat_q, stat_d, nresp_q, nresp_d;
  logic [AUTH_W-1:0] auth_q, auth_d;
  logic [N_ARC-1:0]  go_q, go_d;
  logic              save_q, save_d, err_q, err_d, done_q, done_d;
  logic              go_s, valid_sel, prev_sel, q_sel, done_sel;
  logic              cap, active, wdog_hit, abort;
  logic [N_ARC-1:0]  sel_onehot, arc_onehot;
  logic [CNT_W-1:0]  evx_max;

  // Select muxes are written as compares so an out-of-range select reads as 0.
  always_comb begin
    valid_sel  = 1'b0;
    prev_sel   = 1'b0;
    q_sel      = 1'b0;
    done_sel   = 1'b0;
    sel_onehot = '0;
    arc_onehot = '0;
    for (int k = 0; k < N_ARC; k++) begin
      if (sel_q == SEL_W'(k)) begin
        valid_sel     = valid_s2_q[k];
        prev_sel      = valid_prev_q[k];
        q_sel         = q_s2_q[k];
        done_sel      = done_s2_q[k];
        sel_onehot[k] = 1'b1;
      end
      if (bus.i_arc == SEL_W'(k)) arc_onehot[k] = 1'b1;
    end
  end

  assign go_s    = go_sync_q[1];
  assign active  = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_WAITLOW);
  assign cap     = valid_sel && !prev_sel && (state_q != S_IDLE) && (state_q != S_HOLD);
  assign abort   = active && (bus.i_abort || wdog_hit);
  assign evx_max = (bus.i_evx == '0) ? CNT_W'(1) : bus.i_evx;

`ifdef PUF_EVAL_SEQ_WDOG_EN
  logic [CNT_W-1:0] wdog_q, wdog_d;

  assign wdog_hit = (bus.i_tmo != '0) && (wdog_q == bus.i_tmo) &&
                    ((state_q == S_RUN) || (state_q == S_WAITLOW));

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == S_START) wdog_d = '0;
    else if ((state_q == S_RUN) || (state_q == S_WAITLOW)) wdog_d = wdog_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    evx_d   = evx_q;
    scc_d   = scc_q;
    stat_d  = stat_q;
    nresp_d = nresp_q;
    auth_d  = auth_q;
    go_d    = go_q;
    save_d  = save_q;
    err_d   = err_q;
    done_d  = done_q;

    if (cap) begin
      auth_d = {auth_q[AUTH_W-2:0], q_sel};
      if (q_sel && (stat_q != '1)) stat_d = stat_q + CNT_W'(1);
      if (nresp_q != '1) nresp_d = nresp_q + CNT_W'(1);
    end

    // o_go is raised on entry to START so both launch latencies stay minimal.
    case (state_q)
      S_IDLE: if (go_s) begin
        sel_d   = bus.i_arc;
        auth_d  = '0;
        stat_d  = '0;
        nresp_d = '0;
        evx_d   = '0;
        err_d   = 1'b0;
        if ({1'b0, bus.i_arc} >= N_SEL) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          go_d    = arc_onehot;
          state_d = S_START;
        end
      end
      S_START: begin
        evx_d   = evx_q + CNT_W'(1);
        scc_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (scc_q == bus.i_scc_end) begin
          save_d = 1'b0;
        end else begin
          scc_d = scc_q + CNT_W'(1);
          if (scc_q == bus.i_scc_begin) save_d = 1'b1;
        end
        if (done_sel) begin
          go_d    = '0;
          state_d = S_WAITLOW;
        end
      end
      S_WAITLOW: if (!done_sel) begin
        if (evx_q >= evx_max) begin
          state_d = S_FIN;
        end else begin
          go_d    = sel_onehot;
          state_d = S_START;
        end
      end
      S_FIN: begin
        save_d  = 1'b0;
        go_d    = '0;
        done_d  = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: if (!go_s) begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      go_d    = '0;
      save_d  = 1'b0;
      err_d   = 1'b1;
      state_d = S_FIN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_sync_q    <= '0;
      valid_s1_q   <= '0;
      valid_s2_q   <= '0;
      valid_prev_q <= '0;
      q_s1_q       <= '0;
      q_s2_q       <= '0;
      done_s1_q    <= '0;
      done_s2_q    <= '0;
      state_q      <= S_IDLE;
      sel_q        <= '0;
      evx_q        <= '0;
      scc_q        <= '0;
      stat_q       <= '0;
      nresp_q      <= '0;
      auth_q       <= '0;
      go_q         <= '0;
      save_q       <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      go_sync_q    <= {go_sync_q[0], bus.i_go};
      valid_s1_q   <= bus.i_valid;
      valid_s2_q   <= valid_s1_q;
      valid_prev_q <= valid_s2_q;
      q_s1_q       <= bus.i_q;
      q_s2_q       <= q_s1_q;
      done_s1_q    <= bus.i_done;
      done_s2_q    <= done_s1_q;
      state_q      <= state_d;
      sel_q        <= sel_d;
      evx_q        <= evx_d;
      scc_q        <= scc_d;
      stat_q       <= stat_d;
      nresp_q      <= nresp_d;
      auth_q       <= auth_d;
      go_q         <= go_d;
      save_q       <= save_d;
      err_q        <= err_d;
      done_q       <= done_d;
    end
  end

  assign bus.o_go    = go_q;
  assign bus.o_auth  = auth_q;
  assign bus.o_stat  = stat_q;
  assign bus.o_nresp = nresp_q;
  assign bus.o_save  = save_q;
  assign bus.o_busy  = active || (state_q == S_FIN);
  assign bus.o_err   = err_q;
  assign bus.o_done  = done_q;

endmodule
